// File: rtl/cmos_frame_crop.sv
// Crops a window out of the camera pixel stream and re-times it by one clock.
// Define CROP_TEST_PATTERN_EN to replace cropped pixels with 8 vertical colour bars.
module cmos_frame_crop #(
  parameter int H_START  = 0,
  parameter int V_START  = 0,
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int VS_POL   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_i,
  input  logic        de_i,
  input  logic [15:0] pdata_i,
  output logic [15:0] pdata_o,
  output logic        de_o,
  output logic        vs_o,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [11:0] H_LO      = 12'(H_START);
  localparam logic [11:0] H_HI      = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] V_LO      = 12'(V_START);
  localparam logic [11:0] V_HI      = 12'(V_START + V_ACTIVE);
  localparam logic [11:0] COL_LAST  = 12'(H_START + H_ACTIVE - 1);
  localparam logic [11:0] LINE_LAST = 12'(V_START + V_ACTIVE - 1);
  localparam logic [10:0] CNT_MAX   = 11'd2047;
  localparam logic        VS_LVL    = (VS_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {WAIT_SYNC, VSYNC, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        vs_q, de_q;
  logic [10:0] col_q, col_d, line_q, line_d;
  logic [15:0] pdata_q, pdata_d;
  logic        de_o_q, de_o_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic        done_seen_q, done_seen_d;

  logic        vs_act, de_eff, vs_rise, de_fall, col_in, line_in, pass;
  logic [15:0] pix_val;

`ifdef CROP_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  logic [11:0] crop_col, bar_num;

  always_comb begin
    crop_col = {1'b0, col_q} - H_LO;
    bar_num  = crop_col / 12'(BAR_W);
    case (bar_num)
      12'd0:   pix_val = 16'hFFFF;
      12'd1:   pix_val = 16'hFFE0;
      12'd2:   pix_val = 16'h07FF;
      12'd3:   pix_val = 16'h07E0;
      12'd4:   pix_val = 16'hF81F;
      12'd5:   pix_val = 16'hF800;
      12'd6:   pix_val = 16'h001F;
      default: pix_val = 16'h0000;
    endcase
  end
`else
  assign pix_val = pdata_i;
`endif

  // Pixels during vsync are dropped before edge detection, so they never count.
  always_comb begin
    vs_act  = (vsync_i == VS_LVL);
    de_eff  = de_i & ~vs_act;
    vs_rise = vs_act & ~vs_q;
    de_fall = de_q & ~de_eff;
    col_in  = ({1'b0, col_q} >= H_LO) && ({1'b0, col_q} < H_HI);
    line_in = ({1'b0, line_q} >= V_LO) && ({1'b0, line_q} < V_HI);
    pass    = (state_q == ACTIVE) && de_eff && col_in && line_in;
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    line_d        = line_q;
    pdata_d       = pdata_q;
    de_o_d        = pass;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    done_seen_d   = done_seen_q;

    case (state_q)
      WAIT_SYNC: if (vs_rise) state_d = VSYNC;
      VSYNC:     if (!vs_act) state_d = ACTIVE;
      ACTIVE: begin
        if (vs_rise) begin
          state_d       = VSYNC;
          frame_start_d = 1'b1;
          frame_err_d   = ~done_seen_q;
        end
      end
      default:   state_d = WAIT_SYNC;
    endcase

    if (vs_rise) begin
      col_d       = '0;
      line_d      = '0;
      done_seen_d = 1'b0;
    end else if (de_eff) begin
      col_d = (col_q == CNT_MAX) ? col_q : col_q + 11'd1;
    end else if (de_fall) begin
      col_d  = '0;
      line_d = (line_q == CNT_MAX) ? line_q : line_q + 11'd1;
    end

    if (pass) begin
      pdata_d = pix_val;
      if (({1'b0, col_q} == COL_LAST) && ({1'b0, line_q} == LINE_LAST) && !done_seen_q) begin
        frame_done_d = 1'b1;
        done_seen_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_SYNC;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      col_q         <= '0;
      line_q        <= '0;
      pdata_q       <= '0;
      de_o_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      done_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_act;
      de_q          <= de_eff;
      col_q         <= col_d;
      line_q        <= line_d;
      pdata_q       <= pdata_d;
      de_o_q        <= de_o_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      done_seen_q   <= done_seen_d;
    end
  end

  assign pdata_o     = pdata_q;
  assign de_o        = de_o_q;
  assign vs_o        = vs_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_cmos_frame_crop.sv
// Randomised frame bench for cmos_frame_crop with a geometry-level crop model.
module tb_cmos_frame_crop;

  localparam int H_START  = 5;
  localparam int V_START  = 3;
  localparam int H_ACTIVE = 16;
  localparam int V_ACTIVE = 8;
  localparam int H_END    = H_START + H_ACTIVE;
  localparam int V_END    = V_START + V_ACTIVE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_i = 1'b0;
  logic        de_i = 1'b0;
  logic [15:0] pdata_i = '0;
  logic [15:0] pdata_o;
  logic        de_o, vs_o, frame_start, frame_done, frame_err;

  cmos_frame_crop #(
    .H_START(H_START), .V_START(V_START), .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE), .VS_POL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
    .pdata_o(pdata_o), .de_o(de_o), .vs_o(vs_o), .frame_start(frame_start),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    bit          done;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          obs_start = 0, obs_done = 0, obs_err = 0, obs_de = 0;
  int          exp_start = 0, exp_done = 0, exp_err = 0;
  bit          synced = 0;
  bit          done_flag = 0;
  logic [15:0] last_out = '0;
  int          line_w[64];

`ifdef CROP_TEST_PATTERN_EN
  function automatic logic [15:0] barColor(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Every valid output is matched in order against what the crop window should emit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start) obs_start++;
      if (frame_done)  obs_done++;
      if (frame_err)   obs_err++;
      if (de_o) begin
        obs_de++;
        if (expq.size() == 0) begin
          checkOutput("spurious_de_o", 32'(de_o), 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          checkOutput("pdata_o", 32'(pdata_o), 32'(e.data));
          checkOutput("latency", 32'(cyc), 32'(e.cyc));
          checkOutput("frame_done_with_pixel", 32'(frame_done), 32'(e.done));
          last_out = e.data;
        end
      end else begin
        checkOutput("pdata_hold", 32'(pdata_o), 32'(last_out));
        if (frame_done) checkOutput("frame_done_without_de", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic driveCycle(input logic vs, input logic de, input logic [15:0] d);
    @(posedge clk);
    #1;
    vsync_i = vs;
    de_i    = de;
    pdata_i = d;
  endtask

  task automatic driveLine(input int l, input int w);
    for (int c = 0; c < w; c++) begin
      logic [15:0] d;
      bit          pass, last;
      exp_t        e;
      d    = 16'($urandom);
      pass = synced && (l >= V_START) && (l < V_END) && (c >= H_START) && (c < H_END);
      last = pass && (c == H_END - 1) && (l == V_END - 1) && !done_flag;
      driveCycle(1'b0, 1'b1, d);
      if (pass) begin
`ifdef CROP_TEST_PATTERN_EN
        e.data = barColor((c - H_START) / (H_ACTIVE / 8));
`else
        e.data = d;
`endif
        e.done = last;
        e.cyc  = cyc + 1;
        expq.push_back(e);
      end
      if (last) begin
        done_flag = 1;
        exp_done++;
      end
    end
  endtask

  // One vsync pulse (closing the previous frame) followed by nlines camera lines.
  task automatic applyStimulus(input int nlines);
    if (synced) begin
      exp_start++;
      if (!done_flag) exp_err++;
    end
    synced    = 1;
    done_flag = 0;
    for (int i = 0; i < 4; i++) driveCycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
    checkOutput("vs_o_high", 32'(vs_o), 32'd1);
    driveCycle(1'b0, 1'b0, 16'($urandom));
    driveCycle(1'b0, 1'b0, 16'($urandom));
    checkOutput("vs_o_low", 32'(vs_o), 32'd0);
    checkOutput("frame_start_count", 32'(obs_start), 32'(exp_start));
    checkOutput("frame_done_count", 32'(obs_done), 32'(exp_done));
    checkOutput("frame_err_count", 32'(obs_err), 32'(exp_err));
    for (int l = 0; l < nlines; l++) begin
      int gap;
      driveLine(l, line_w[l]);
      driveCycle(1'b0, 1'b0, 16'($urandom));
      if (line_w[l] >= 2048) checkOutput("col_saturate", 32'(dut.col_q), 32'd2047);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) driveCycle(1'b0, 1'b0, 16'($urandom));
    end
  endtask

  task automatic driveJunk(input int ncyc);
    for (int c = 0; c < ncyc; c++) driveCycle(1'b0, 1'((c % 30) < 24), 16'($urandom));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pdata_o"}, 32'(pdata_o), 32'd0);
    checkOutput({tag, "_de_o"}, 32'(de_o), 32'd0);
    checkOutput({tag, "_vs_o"}, 32'(vs_o), 32'd0);
    checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    #23;
    checkResetOutputs("reset");

    // Reset released in the middle of a camera line: nothing may come out before a full vsync.
    for (int c = 0; c < 40; c++) begin
      driveCycle(1'b0, 1'((c % 12) < 9), 16'($urandom));
      if (c == 15) rst_n = 1'b1;
    end
    driveJunk(30 * 14);
    checkOutput("no_output_before_sync", 32'(obs_de), 32'd0);

    for (int l = 0; l < 64; l++) line_w[l] = 26;
    applyStimulus(14);
    applyStimulus(6);

    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(8, 16));
      for (int l = 0; l < 64; l++) line_w[l] = int'($urandom_range(10, 30));
      applyStimulus(n);
    end

    for (int l = 0; l < 64; l++) line_w[l] = 24;
    line_w[5] = 3000;
    applyStimulus(12);

    // Asynchronous reset while cropped pixels are flowing.
    for (int l = 0; l < 64; l++) line_w[l] = 26;
    applyStimulus(6);
    driveLine(6, 8);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    expq.delete();
    synced    = 0;
    done_flag = 0;
    last_out  = '0;
    obs_de    = 0;
    driveJunk(20);
    rst_n = 1'b1;
    driveJunk(30 * 12);
    checkOutput("no_output_after_async_reset", 32'(obs_de), 32'd0);

    applyStimulus(13);
    for (int l = 0; l < 64; l++) line_w[l] = int'($urandom_range(18, 30));
    applyStimulus(12);
    applyStimulus(0);

    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmos_frame_crop.md
CMOS_FRAME_CROP -- requirements
Module: cmos_frame_crop

Interface
REQ-001 SHALL have parameter H_START, default 0, first camera column passed per line.
REQ-002 SHALL have parameter V_START, default 0, first camera line passed per frame.
REQ-003 SHALL have parameter H_ACTIVE, default 480, columns passed per line.
REQ-004 SHALL have parameter V_ACTIVE, default 272, lines passed per frame.
REQ-005 SHALL have parameter VS_POL, default 1, active level of vsync_i.
REQ-006 SHALL have port clk, input, 1, camera pixel clock (cmos_pclk domain); the block has one clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port vsync_i, input, 1, camera vsync.
REQ-009 SHALL have port de_i, input, 1, 16-bit pixel valid from the 8-to-16 converter.
REQ-010 SHALL have port pdata_i, input, 16, RGB565 pixel.
REQ-011 SHALL have port pdata_o, output, 16, cropped pixel.
REQ-012 SHALL have port de_o, output, 1, cropped pixel valid (FIFO write enable).
REQ-013 SHALL have port vs_o, output, 1, vsync_i registered and normalised to active-high.
REQ-014 SHALL have port frame_start, output, 1, one-cycle pulse at frame boundary.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse with last cropped pixel.
REQ-016 SHALL have port frame_err, output, 1, one-cycle pulse on short frame.

Function
REQ-017 SHALL implement states WAIT_SYNC, VSYNC, ACTIVE; reset enters WAIT_SYNC.
REQ-018 WAIT_SYNC SHALL discard all pixels and move to VSYNC on first vsync_i assertion edge, so a partial frame after reset is never output.
REQ-019 VSYNC SHALL move to ACTIVE on vsync_i deassertion; ACTIVE SHALL move to VSYNC on vsync_i assertion edge.
REQ-020 frame_start SHALL pulse one cycle after each vsync_i assertion edge seen in VSYNC or ACTIVE entry path (not from WAIT_SYNC).
REQ-021 11-bit column counter SHALL increment per de_i cycle, clear on de_i falling edge and at frame boundary, and saturate at 2047.
REQ-022 11-bit line counter SHALL increment on de_i falling edge, clear at frame boundary, and saturate at 2047.
REQ-023 A pixel SHALL pass iff state is ACTIVE, de_i=1, H_START<=col<H_START+H_ACTIVE, V_START<=line<V_START+V_ACTIVE.
REQ-024 pdata_o/de_o SHALL be registered: latency exactly 1 clk from pdata_i/de_i; pdata_o holds last value when de_o=0.
REQ-025 de_i asserted while vsync_i active SHALL be ignored (no count, no output).
REQ-026 frame_done SHALL pulse coincident with de_o for pixel (H_ACTIVE-1, V_ACTIVE-1) of the cropped window, at most once per frame.
REQ-027 frame_err SHALL pulse one cycle after an ACTIVE-to-VSYNC transition if frame_done did not fire that frame.
REQ-028 Lines shorter than H_START+H_ACTIVE SHALL output only the columns present; no padding.
REQ-029 vsync_i and de_i SHALL be compared against one-cycle-delayed copies for edge detection.

Reset
REQ-030 On rst_n=0, pdata_o=0, de_o=0, vs_o=0, frame_start=0, frame_done=0, frame_err=0, counters=0, state=WAIT_SYNC, immediately and asynchronously.
REQ-031 Reset deassertion mid-frame SHALL produce no output until a full vsync cycle passes (REQ-018).

Configuration
REQ-032 With macro CROP_TEST_PATTERN_EN defined, pdata_o SHALL carry 8 vertical colour bars (each H_ACTIVE/8 wide, order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000) indexed by cropped column, with de_o/timing unchanged; without it, pdata_o SHALL equal the passed pdata_i and no pattern logic SHALL be built.

Verification
REQ-033 Reset released mid-frame, de_i toggling -> de_o stays 0 until after next vsync assertion and deassertion.
REQ-034 Defaults, 640x480 camera frames -> exactly 480 de_o per line for lines 0..271, 130560 total, one frame_start, one frame_done, no frame_err.
REQ-035 H_START=80, V_START=104, pixel value = column index -> first de_o of each line carries 80, last carries 559, latency 1 clk.
REQ-036 Frame cut to 200 lines then vsync asserted -> frame_err pulses once, no frame_done.
REQ-037 de_i pulsed during vsync active, and line of 3000 pixels -> no output during vsync; column counter holds 2047, no wrap-induced output.
REQ-038 CROP_TEST_PATTERN_EN defined -> cropped columns 0..59 = FFFF, 60..119 = FFE0, 420..479 = 0000.
